drum_mul_arbiter: RTL and testbench
===================================

// Module: drum_mul_arbiter
// PURPOSE
//   Round-robin arbiter and sequencer that shares one drum approximate multiplier between two requesters.
//   Each requester uses a valid/ready operand port. The block registers the operands of the granted request,
//   drives the combinational drum datapath for MUL_LAT cycles (multicycle path), then registers the product.
//   The product is presented on one valid/ready result port, tagged with its source.
//   Sits between the tt_um_drum_goekce pin wrapper logic and the drum instance.
// PARAMETERS
//   K       4  drum truncation width, passed to the drum instance as k
//   N       4  operand a width (signed, MSB = sign)
//   M       4  operand b width (signed, MSB = sign)
//   MUL_LAT 2  cycles the datapath is held before result capture; legal range 1..15
// PORTS
//   clk       in   1    clock; all state changes on rising edge
//   rst       in   1    synchronous, active-high reset
//   s0_valid  in   1    requester 0 operand valid
//   s0_ready  out  1    requester 0 operand accepted this cycle
//   s0_a      in   N    requester 0 operand a
//   s0_b      in   M    requester 0 operand b
//   s0_exact  in   1    requester 0 exact-mode request (DRUM_EXACT_EN only)
//   s1_valid, s1_ready, s1_a, s1_b, s1_exact   requester 1 ports; same widths and meaning as requester 0
//   m_valid   out  1    result valid
//   m_ready   in   1    result consumer ready
//   m_r       out  N+M  product
//   m_src     out  1    index of the requester that issued m_r
//   busy      out  1    high whenever state != IDLE
//   done_cnt  out  8    completed-transfer counter; wraps 255->0
// BEHAVIOUR
//   Reset values
//     state=IDLE, m_valid=0, m_r=0, m_src=0, busy=0, done_cnt=0.
//     last=1, so s0 wins the first contention.
//     rst aborts any in-flight operation; the result is discarded and never presented.
//   FSM states: IDLE -> EXEC -> DONE -> IDLE.
//   IDLE
//     Grant = the only valid requester. If both are valid, grant = ~last.
//     sX_ready = (state==IDLE) & grant==X & sX_valid. This is combinational; at most one ready is high per cycle.
//     On transfer: capture a, b, exact and src into the op registers; last<=src; lat_cnt<=MUL_LAT-1; go to EXEC.
//   EXEC
//     The drum instance is fed only from the op registers; port operands are never sampled outside a transfer.
//     lat_cnt decrements each cycle.
//     At lat_cnt==0: m_r<=product, m_src<=src, m_valid<=1, go to DONE.
//     Latency: a transfer at edge t gives m_valid=1 from edge t+MUL_LAT.
//   DONE
//     m_r and m_src are held stable while m_valid & ~m_ready.
//     On m_ready: m_valid<=0, done_cnt<=done_cnt+1, go to IDLE.
//     No new operand is accepted in this cycle. Peak throughput is 1 result per MUL_LAT+2 cycles.
//   s0_ready=0 and s1_ready=0 outside IDLE. Requests that stay valid are held off and are not dropped.
//   Arithmetic
//     Operands are converted to magnitudes by one's-complement inversion when the MSB is set.
//     Result sign = a[N-1]^b[M-1]; a negative result is the one's complement of the magnitude product.
//     No saturation; the product is always exactly N+M bits.
// CONFIGURATION
//   DRUM_EXACT_EN defined
//     Adds an exact signed multiplier (two's complement a*b, N+M bits) alongside the drum instance.
//     The captured exact bit selects the exact product instead of the drum product at capture.
//   DRUM_EXACT_EN undefined
//     No exact multiplier is built. s0_exact and s1_exact are ignored.
//     Results are always drum products.
// TESTING (K=4, N=4, M=4, MUL_LAT=2 unless noted)
//   Single request: s0 a=3, b=2.
//     -> s0_ready in the same cycle; m_valid 2 cycles after the transfer.
//     -> m_r=8'h06, m_src=0, done_cnt=1 after m_ready.
//   Negative operand: s1 a=4'hE, b=3, exact=0.
//     -> m_r=8'hFC, m_src=1.
//   Exact mode, DRUM_EXACT_EN only: the same operands with exact=1.
//     -> m_r=8'hFA.
//     -> With the macro undefined -> m_r=8'hFC.
//   Contention: s0 and s1 both valid right after reset, m_ready=1.
//     -> Grant order s0, s1, s0, s1; never two readies in one cycle.
//   Backpressure: m_ready=0 for 5 cycles while DONE.
//     -> m_r stable, s0_ready=s1_ready=0, busy=1.
//     -> Completes on the first m_ready=1 cycle.
//   Reset in EXEC: rst for 1 cycle.
//     -> Next cycle all outputs return to their reset values.
//     -> The aborted result never appears on m_valid; the next contention grants s0 first.

Source files
------------

// File: rtl/drum_mul_arbiter_if.sv
// rtl/drum_mul_arbiter_if.sv - requester, result and status bundle for drum_mul_arbiter
interface drum_mul_arbiter_if #(
    parameter int N = 4,
    parameter int M = 4
);
    logic           s0_valid;
    logic           s0_ready;
    logic [N-1:0]   s0_a;
    logic [M-1:0]   s0_b;
    logic           s0_exact;

    logic           s1_valid;
    logic           s1_ready;
    logic [N-1:0]   s1_a;
    logic [M-1:0]   s1_b;
    logic           s1_exact;

    logic           m_valid;
    logic           m_ready;
    logic [N+M-1:0] m_r;
    logic           m_src;

    logic           busy;
    logic [7:0]     done_cnt;

    modport slave (
        input  s0_valid, s0_a, s0_b, s0_exact,
        input  s1_valid, s1_a, s1_b, s1_exact,
        input  m_ready,
        output s0_ready, s1_ready,
        output m_valid, m_r, m_src,
        output busy, done_cnt
    );

    modport master (
        output s0_valid, s0_a, s0_b, s0_exact,
        output s1_valid, s1_a, s1_b, s1_exact,
        output m_ready,
        input  s0_ready, s1_ready,
        input  m_valid, m_r, m_src,
        input  busy, done_cnt
    );
endinterface

// File: rtl/drum_mul_arbiter.sv
// rtl/drum_mul_arbiter.sv - two-requester round-robin sequencer around a shared drum multiplier
// Optional exact signed multiplier selected per operation when DRUM_EXACT_EN is defined.
module drum #(
    parameter int k = 4,
    parameter int N = 4,
    parameter int M = 4
) (
    input  logic [N-1:0]   a,
    input  logic [M-1:0]   b,
    output logic [N+M-1:0] r
);
    localparam int W = N + M;

    logic [N-1:0] mag_a;
    logic [M-1:0] mag_b;
    logic [W-1:0] ta;
    logic [W-1:0] tb;
    logic [W-1:0] prod;
    int           sa;
    int           sb;

    // Keep k bits from the leading one down; forcing the kept LSB to 1 unbiases the truncation.
    always_comb begin
        mag_a = a ^ {N{a[N-1]}};
        mag_b = b ^ {M{b[M-1]}};
        sa = 0;
        sb = 0;
        for (int i = 0; i < N; i++) begin
            if (mag_a[i] && (i >= k)) sa = i - k + 1;
        end
        for (int j = 0; j < M; j++) begin
            if (mag_b[j] && (j >= k)) sb = j - k + 1;
        end
        ta = W'(mag_a) >> sa;
        tb = W'(mag_b) >> sb;
        if (sa != 0) ta[0] = 1'b1;
        if (sb != 0) tb[0] = 1'b1;
        prod = (ta * tb) << (sa + sb);
        r = (a[N-1] ^ b[M-1]) ? ~prod : prod;
    end
endmodule

module drum_mul_arbiter #(
    parameter int K       = 4,
    parameter int N       = 4,
    parameter int M       = 4,
    parameter int MUL_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    drum_mul_arbiter_if.slave bus
);
    localparam int         W        = N + M;
    localparam logic [3:0] LAT_INIT = 4'(MUL_LAT - 1);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t         state;
    state_t         state_nxt;
    logic           last;
    logic           grant;
    logic           xfer;
    logic           s0_ready;
    logic           s1_ready;
    logic           busy;
    logic [N-1:0]   op_a;
    logic [M-1:0]   op_b;
    logic           op_src;
    logic [3:0]     lat_cnt;
    logic [W-1:0]   drum_r;
    logic [W-1:0]   product;
    logic           m_valid;
    logic [W-1:0]   m_r;
    logic           m_src;
    logic [7:0]     done_cnt;

    // Lone requester wins; on contention the one not served last wins.
    assign grant = bus.s1_valid & (~bus.s0_valid | ~last);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (xfer)            state_nxt = EXEC;
            EXEC:    if (lat_cnt == 4'd0) state_nxt = DONE;
            DONE:    if (bus.m_ready)     state_nxt = IDLE;
            default:                      state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s0_ready = 1'b0;
        s1_ready = 1'b0;
        busy     = (state != IDLE);
        if (state == IDLE) begin
            s0_ready = ~grant & bus.s0_valid;
            s1_ready =  grant & bus.s1_valid;
        end
        xfer = s0_ready | s1_ready;
    end

    // Datapath is driven only from the op registers, so its multicycle window is stable.
    drum #(.k(K), .N(N), .M(M)) u_drum (
        .a (op_a),
        .b (op_b),
        .r (drum_r)
    );

`ifdef DRUM_EXACT_EN
    logic         op_exact;
    logic [W-1:0] exact_r;

    assign exact_r = $signed({{M{op_a[N-1]}}, op_a}) * $signed({{N{op_b[M-1]}}, op_b});
    assign product = op_exact ? exact_r : drum_r;

    always_ff @(posedge clk) begin
        if (rst)       op_exact <= 1'b0;
        else if (xfer) op_exact <= grant ? bus.s1_exact : bus.s0_exact;
    end
`else
    logic unused_exact;

    assign unused_exact = bus.s0_exact ^ bus.s1_exact;
    assign product      = drum_r;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            last     <= 1'b1;
            op_a     <= '0;
            op_b     <= '0;
            op_src   <= 1'b0;
            lat_cnt  <= 4'd0;
            m_valid  <= 1'b0;
            m_r      <= '0;
            m_src    <= 1'b0;
            done_cnt <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (xfer) begin
                        op_a    <= grant ? bus.s1_a : bus.s0_a;
                        op_b    <= grant ? bus.s1_b : bus.s0_b;
                        op_src  <= grant;
                        last    <= grant;
                        lat_cnt <= LAT_INIT;
                    end
                end
                EXEC: begin
                    if (lat_cnt == 4'd0) begin
                        m_r     <= product;
                        m_src   <= op_src;
                        m_valid <= 1'b1;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                DONE: begin
                    if (bus.m_ready) begin
                        m_valid  <= 1'b0;
                        done_cnt <= done_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.s0_ready = s0_ready;
    assign bus.s1_ready = s1_ready;
    assign bus.busy     = busy;
    assign bus.m_valid  = m_valid;
    assign bus.m_r      = m_r;
    assign bus.m_src    = m_src;
    assign bus.done_cnt = done_cnt;
endmodule

// File: tb/tb_drum_mul_arbiter.sv
// tb/tb_drum_mul_arbiter.sv - directed self-checking bench for drum_mul_arbiter
module tb_drum_mul_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   exp_done = 0;
    int   n;
    int   both_cnt;
    int   nrec;
    int   seen_valid;
    logic [7:0] held_r;
    logic grants [4];

    always #5 clk = ~clk;

    drum_mul_arbiter_if #(.N(4), .M(4)) bus ();

    drum_mul_arbiter #(.K(4), .N(4), .M(4), .MUL_LAT(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic src, input logic [3:0] a, input logic [3:0] b, input logic ex);
        int k;
        if (src) begin
            bus.s1_a = a; bus.s1_b = b; bus.s1_exact = ex; bus.s1_valid = 1'b1;
        end else begin
            bus.s0_a = a; bus.s0_b = b; bus.s0_exact = ex; bus.s0_valid = 1'b1;
        end
        #1;
        k = 0;
        while (!(src ? bus.s1_ready : bus.s0_ready) && k < 20) begin
            tick();
            k++;
        end
        check("issue_ready_timeout", 16'(k < 20), 16'd1);
        tick();
        bus.s0_valid = 1'b0;
        bus.s1_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!bus.m_valid && cyc < 20) begin
            tick();
            cyc++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.s0_valid = 1'b0; bus.s0_a = '0; bus.s0_b = '0; bus.s0_exact = 1'b0;
        bus.s1_valid = 1'b0; bus.s1_a = '0; bus.s1_b = '0; bus.s1_exact = 1'b0;
        bus.m_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;

        check("rst_m_valid",  16'(bus.m_valid),  16'd0);
        check("rst_m_r",      16'(bus.m_r),      16'h00);
        check("rst_m_src",    16'(bus.m_src),    16'd0);
        check("rst_busy",     16'(bus.busy),     16'd0);
        check("rst_done_cnt", 16'(bus.done_cnt), 16'd0);

        // single request s0: 3*2
        bus.s0_a = 4'd3; bus.s0_b = 4'd2; bus.s0_valid = 1'b1;
        #1;
        check("single_s0_ready", 16'(bus.s0_ready), 16'd1);
        check("single_s1_ready", 16'(bus.s1_ready), 16'd0);
        tick();
        bus.s0_valid = 1'b0;
        check("single_busy",       16'(bus.busy),    16'd1);
        check("single_valid_t0",   16'(bus.m_valid), 16'd0);
        tick();
        check("single_valid_t1",   16'(bus.m_valid), 16'd0);
        tick();
        check("single_valid_t2",   16'(bus.m_valid), 16'd1);
        check("single_m_r",        16'(bus.m_r),     16'h06);
        check("single_m_src",      16'(bus.m_src),   16'd0);
        bus.m_ready = 1'b1;
        tick();
        bus.m_ready = 1'b0;
        exp_done++;
        check("single_valid_clr",  16'(bus.m_valid),  16'd0);
        check("single_done_cnt",   16'(bus.done_cnt), 16'(exp_done));
        check("single_idle",       16'(bus.busy),     16'd0);

        // negative operand from s1: -1 (one's complement) * 3
        issue(1'b1, 4'hE, 4'd3, 1'b0);
        wait_valid(n);
        check("neg_latency", 16'(n), 16'd2);
        check("neg_m_r",     16'(bus.m_r),   16'hFC);
        check("neg_m_src",   16'(bus.m_src), 16'd1);
        bus.m_ready = 1'b1;
        tick();
        bus.m_ready = 1'b0;
        exp_done++;
        check("neg_done_cnt", 16'(bus.done_cnt), 16'(exp_done));

        // exact-mode request
        issue(1'b1, 4'hE, 4'd3, 1'b1);
        wait_valid(n);
        check("exact_latency", 16'(n), 16'd2);
`ifdef DRUM_EXACT_EN
        check("exact_m_r", 16'(bus.m_r), 16'hFA);
`else
        check("exact_m_r", 16'(bus.m_r), 16'hFC);
`endif
        bus.m_ready = 1'b1;
        tick();
        bus.m_ready = 1'b0;
        exp_done++;
        check("exact_done_cnt", 16'(bus.done_cnt), 16'(exp_done));

        // contention right after reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_done = 0;
        bus.s0_a = 4'd1; bus.s0_b = 4'd1; bus.s0_exact = 1'b0; bus.s0_valid = 1'b1;
        bus.s1_a = 4'd2; bus.s1_b = 4'd2; bus.s1_exact = 1'b0; bus.s1_valid = 1'b1;
        bus.m_ready = 1'b1;
        #1;
        both_cnt = 0;
        nrec = 0;
        for (int c = 0; c < 60 && nrec < 4; c++) begin
            if (bus.s0_ready && bus.s1_ready) both_cnt++;
            if (bus.s0_ready) begin
                grants[nrec] = 1'b0;
                nrec++;
            end else if (bus.s1_ready) begin
                grants[nrec] = 1'b1;
                nrec++;
            end
            tick();
        end
        bus.s0_valid = 1'b0;
        bus.s1_valid = 1'b0;
        n = 0;
        while (bus.busy && n < 20) begin
            tick();
            n++;
        end
        exp_done = 4;
        check("cont_grant_count", 16'(nrec), 16'd4);
        check("cont_grant0", 16'(grants[0]), 16'd0);
        check("cont_grant1", 16'(grants[1]), 16'd1);
        check("cont_grant2", 16'(grants[2]), 16'd0);
        check("cont_grant3", 16'(grants[3]), 16'd1);
        check("cont_two_readies", 16'(both_cnt), 16'd0);
        check("cont_done_cnt", 16'(bus.done_cnt), 16'(exp_done));
        bus.m_ready = 1'b0;

        // backpressure: result 5*1 held for 5 cycles with both requesters pending
        issue(1'b0, 4'd5, 4'd1, 1'b0);
        wait_valid(n);
        check("bp_latency", 16'(n), 16'd2);
        held_r = bus.m_r;
        check("bp_m_r", 16'(held_r), 16'h05);
        bus.s0_a = 4'd6; bus.s0_b = 4'd1; bus.s0_valid = 1'b1;
        bus.s1_a = 4'd1; bus.s1_b = 4'd1; bus.s1_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("bp_hold_m_r",   16'(bus.m_r),      16'h05);
            check("bp_hold_valid", 16'(bus.m_valid),  16'd1);
            check("bp_hold_rdy0",  16'(bus.s0_ready), 16'd0);
            check("bp_hold_rdy1",  16'(bus.s1_ready), 16'd0);
            check("bp_hold_busy",  16'(bus.busy),     16'd1);
            tick();
        end
        bus.m_ready = 1'b1;
        tick();
        bus.m_ready = 1'b0;
        exp_done++;
        check("bp_valid_clr", 16'(bus.m_valid),  16'd0);
        check("bp_done_cnt",  16'(bus.done_cnt), 16'(exp_done));
        check("bp_idle",      16'(bus.busy),     16'd0);
        check("bp_rr_rdy1",   16'(bus.s1_ready), 16'd1);
        check("bp_rr_rdy0",   16'(bus.s0_ready), 16'd0);
        tick();
        bus.s0_valid = 1'b0;
        bus.s1_valid = 1'b0;

        // reset while s1's operation is in EXEC
        check("rst_exec_busy", 16'(bus.busy), 16'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_exec_m_valid",  16'(bus.m_valid),  16'd0);
        check("rst_exec_m_r",      16'(bus.m_r),      16'h00);
        check("rst_exec_m_src",    16'(bus.m_src),    16'd0);
        check("rst_exec_busy0",    16'(bus.busy),     16'd0);
        check("rst_exec_done_cnt", 16'(bus.done_cnt), 16'd0);
        seen_valid = 0;
        for (int c = 0; c < 6; c++) begin
            if (bus.m_valid) seen_valid++;
            tick();
        end
        check("rst_exec_no_result", 16'(seen_valid), 16'd0);
        bus.s0_valid = 1'b1;
        bus.s1_valid = 1'b1;
        #1;
        check("rst_exec_first_s0", 16'(bus.s0_ready), 16'd1);
        check("rst_exec_first_s1", 16'(bus.s1_ready), 16'd0);
        bus.s0_valid = 1'b0;
        bus.s1_valid = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
